// File: rtl/idex_skid_stage_pkg.sv
// Shared widths, payload sizing and field offsets for the ID/EX skid stage.
package idex_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int OP_W   = 6;
  localparam int WB_W   = 2;
  localparam int M_W    = 3;
  localparam int EX_W   = 4;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_MAIN  = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_e;

  // Payload fields, LSB first; OpCode occupies bit 0 upward.
  typedef enum logic [3:0] {
    F_OP, F_RD, F_RT, F_RS, F_IMM, F_B, F_A, F_EX, F_M, F_WB
  } field_e;

  function automatic int pay_w(int data_w, int reg_w, int op_w,
                               int wb_w, int m_w, int ex_w);
    return wb_w + m_w + ex_w + 3 * data_w + 3 * reg_w + op_w;
  endfunction

  function automatic int field_off(field_e f, int data_w, int reg_w,
                                   int op_w, int m_w, int ex_w);
    int off;
    off = 0;
    if (f > F_OP)  off += op_w;
    if (f > F_RD)  off += reg_w;
    if (f > F_RT)  off += reg_w;
    if (f > F_RS)  off += reg_w;
    if (f > F_IMM) off += data_w;
    if (f > F_B)   off += data_w;
    if (f > F_A)   off += data_w;
    if (f > F_EX)  off += ex_w;
    if (f > F_M)   off += m_w;
    return off;
  endfunction

endpackage

// File: rtl/idex_skid_stage_if.sv
// Decode-side and execute-side handshake plus instruction fields of the ID/EX stage.
interface idex_skid_stage_if #(
  parameter int DATA_W = idex_pkg::DATA_W,
  parameter int REG_W  = idex_pkg::REG_W,
  parameter int OP_W   = idex_pkg::OP_W,
  parameter int WB_W   = idex_pkg::WB_W,
  parameter int M_W    = idex_pkg::M_W,
  parameter int EX_W   = idex_pkg::EX_W
);
  logic              in_valid;
  logic              in_ready;
  logic [WB_W-1:0]   WB;
  logic [M_W-1:0]    M;
  logic [EX_W-1:0]   EX;
  logic [DATA_W-1:0] DataA;
  logic [DATA_W-1:0] DataB;
  logic [DATA_W-1:0] imm_value;
  logic [REG_W-1:0]  RegRs;
  logic [REG_W-1:0]  RegRt;
  logic [REG_W-1:0]  RegRd;
  logic [OP_W-1:0]   OpCode;

  logic              out_valid;
  logic              out_ready;
  logic [WB_W-1:0]   WBreg;
  logic [M_W-1:0]    Mreg;
  logic [EX_W-1:0]   EXreg;
  logic [DATA_W-1:0] DataAreg;
  logic [DATA_W-1:0] DataBreg;
  logic [DATA_W-1:0] imm_valuereg;
  logic [REG_W-1:0]  RegRsreg;
  logic [REG_W-1:0]  RegRtreg;
  logic [REG_W-1:0]  RegRdreg;
  logic [OP_W-1:0]   RegOpCode;

  modport master (
    output in_valid, WB, M, EX, DataA, DataB, imm_value, RegRs, RegRt, RegRd, OpCode,
    output out_ready,
    input  in_ready, out_valid, WBreg, Mreg, EXreg, DataAreg, DataBreg, imm_valuereg,
    input  RegRsreg, RegRtreg, RegRdreg, RegOpCode
  );

  modport slave (
    input  in_valid, WB, M, EX, DataA, DataB, imm_value, RegRs, RegRt, RegRd, OpCode,
    input  out_ready,
    output in_ready, out_valid, WBreg, Mreg, EXreg, DataAreg, DataBreg, imm_valuereg,
    output RegRsreg, RegRtreg, RegRdreg, RegOpCode
  );
endinterface

// File: rtl/idex_skid_stage_skid_buf.sv
// Generic W-bit, 2-entry valid/ready skid buffer with synchronous flush.
// state      | meaning
// SKID_EMPTY | nothing held, out_valid=0
// SKID_MAIN  | one entry in main, presented downstream
// SKID_FULL  | main presented, skid holds the next one, in_ready=0
module skid_buf #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  import idex_pkg::*;

  skid_state_e state_q, state_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         accept;
  logic         consume;

  assign in_ready  = (state_q != SKID_FULL);
  assign out_valid = (state_q != SKID_EMPTY);
  assign out_data  = main_q;
  assign accept    = in_valid & in_ready;
  assign consume   = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = SKID_EMPTY;
    end else begin
      case (state_q)
        SKID_EMPTY: begin
          if (accept) begin
            main_d  = in_data;
            state_d = SKID_MAIN;
          end
        end
        SKID_MAIN: begin
          if (consume) begin
            if (accept) main_d = in_data;
            else        state_d = SKID_EMPTY;
          end else if (accept) begin
            skid_d  = in_data;
            state_d = SKID_FULL;
          end
        end
        SKID_FULL: begin
          // in_ready is low here, so nothing new can arrive alongside the move
          if (consume) begin
            main_d  = skid_q;
            state_d = SKID_MAIN;
          end
        end
        default: state_d = SKID_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= SKID_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end
endmodule

// File: rtl/idex_skid_stage.sv
// ID/EX pipeline register: packs decode fields into a skid buffer and gates control on out_valid.
// Define IDEX_PERF_CNT_EN to add saturating stall/bubble/flush counters.
module idex_skid_stage #(
  parameter int DATA_W = idex_pkg::DATA_W,
  parameter int REG_W  = idex_pkg::REG_W,
  parameter int OP_W   = idex_pkg::OP_W,
  parameter int WB_W   = idex_pkg::WB_W,
  parameter int M_W    = idex_pkg::M_W,
  parameter int EX_W   = idex_pkg::EX_W
`ifdef IDEX_PERF_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               flush,
  idex_skid_stage_if.slave   bus
`ifdef IDEX_PERF_CNT_EN
  , output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0]   bubble_cnt,
  output logic [CNT_W-1:0]   flush_cnt
`endif
);
  import idex_pkg::*;

  localparam int PAY_W   = pay_w(DATA_W, REG_W, OP_W, WB_W, M_W, EX_W);
  localparam int OFF_OP  = field_off(F_OP,  DATA_W, REG_W, OP_W, M_W, EX_W);
  localparam int OFF_RD  = field_off(F_RD,  DATA_W, REG_W, OP_W, M_W, EX_W);
  localparam int OFF_RT  = field_off(F_RT,  DATA_W, REG_W, OP_W, M_W, EX_W);
  localparam int OFF_RS  = field_off(F_RS,  DATA_W, REG_W, OP_W, M_W, EX_W);
  localparam int OFF_IMM = field_off(F_IMM, DATA_W, REG_W, OP_W, M_W, EX_W);
  localparam int OFF_B   = field_off(F_B,   DATA_W, REG_W, OP_W, M_W, EX_W);
  localparam int OFF_A   = field_off(F_A,   DATA_W, REG_W, OP_W, M_W, EX_W);
  localparam int OFF_EX  = field_off(F_EX,  DATA_W, REG_W, OP_W, M_W, EX_W);
  localparam int OFF_M   = field_off(F_M,   DATA_W, REG_W, OP_W, M_W, EX_W);
  localparam int OFF_WB  = field_off(F_WB,  DATA_W, REG_W, OP_W, M_W, EX_W);

  logic [PAY_W-1:0] pay_in;
  logic [PAY_W-1:0] pay_out;
  logic             out_valid;

  always_comb begin
    pay_in = '0;
    pay_in[OFF_OP  +: OP_W]   = bus.OpCode;
    pay_in[OFF_RD  +: REG_W]  = bus.RegRd;
    pay_in[OFF_RT  +: REG_W]  = bus.RegRt;
    pay_in[OFF_RS  +: REG_W]  = bus.RegRs;
    pay_in[OFF_IMM +: DATA_W] = bus.imm_value;
    pay_in[OFF_B   +: DATA_W] = bus.DataB;
    pay_in[OFF_A   +: DATA_W] = bus.DataA;
    pay_in[OFF_EX  +: EX_W]   = bus.EX;
    pay_in[OFF_M   +: M_W]    = bus.M;
    pay_in[OFF_WB  +: WB_W]   = bus.WB;
  end

  skid_buf #(.W(PAY_W)) u_skid (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   (pay_in),
    .out_valid (out_valid),
    .out_ready (bus.out_ready),
    .out_data  (pay_out)
  );

  assign bus.out_valid = out_valid;

  // An empty slot must look like a NOP downstream, so only control is gated
  assign bus.WBreg        = pay_out[OFF_WB +: WB_W] & {WB_W{out_valid}};
  assign bus.Mreg         = pay_out[OFF_M  +: M_W]  & {M_W{out_valid}};
  assign bus.EXreg        = pay_out[OFF_EX +: EX_W] & {EX_W{out_valid}};
  assign bus.DataAreg     = pay_out[OFF_A   +: DATA_W];
  assign bus.DataBreg     = pay_out[OFF_B   +: DATA_W];
  assign bus.imm_valuereg = pay_out[OFF_IMM +: DATA_W];
  assign bus.RegRsreg     = pay_out[OFF_RS  +: REG_W];
  assign bus.RegRtreg     = pay_out[OFF_RT  +: REG_W];
  assign bus.RegRdreg     = pay_out[OFF_RD  +: REG_W];
  assign bus.RegOpCode    = pay_out[OFF_OP  +: OP_W];

`ifdef IDEX_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    if (out_valid && !bus.out_ready && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_ONE;
    if (!out_valid && (bubble_cnt_q != '1))                 bubble_cnt_d = bubble_cnt_q + CNT_ONE;
    if (flush && (flush_cnt_q != '1))                       flush_cnt_d = flush_cnt_q + CNT_ONE;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
  assign flush_cnt  = flush_cnt_q;
`endif
endmodule

// File: tb/tb_idex_skid_stage.sv
// Scoreboard bench for idex_skid_stage: a queue model of held instructions predicts every output.
module tb_idex_skid_stage;

  typedef struct packed {
    logic [1:0]  wb;
    logic [2:0]  m;
    logic [3:0]  ex;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  op;
  } instr_t;

  logic clock;
  logic reset;
  logic flush;

  idex_skid_stage_if bus ();

`ifdef IDEX_PERF_CNT_EN
  logic [15:0] stall_cnt, bubble_cnt, flush_cnt;
`endif

  idex_skid_stage dut (
    .clock (clock),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
`ifdef IDEX_PERF_CNT_EN
    , .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt),
    .flush_cnt  (flush_cnt)
`endif
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Instructions the stage is holding, oldest first
  instr_t exp_q[$];
  bit     prev_acc;
  bit     prev_fl;
  instr_t prev_p;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic instr_t rand_instr();
    instr_t p;
    p.wb  = 2'($urandom);
    p.m   = 3'($urandom);
    p.ex  = 4'($urandom);
    p.a   = $urandom;
    p.b   = $urandom;
    p.imm = $urandom;
    p.rs  = 5'($urandom);
    p.rt  = 5'($urandom);
    p.rd  = 5'($urandom);
    p.op  = 6'($urandom);
    return p;
  endfunction

  function automatic instr_t observe();
    instr_t p;
    p.wb  = bus.WBreg;
    p.m   = bus.Mreg;
    p.ex  = bus.EXreg;
    p.a   = bus.DataAreg;
    p.b   = bus.DataBreg;
    p.imm = bus.imm_valuereg;
    p.rs  = bus.RegRsreg;
    p.rt  = bus.RegRtreg;
    p.rd  = bus.RegRdreg;
    p.op  = bus.RegOpCode;
    return p;
  endfunction

  task automatic drive(input bit iv, input instr_t p);
    bus.in_valid  = iv;
    bus.WB        = p.wb;
    bus.M         = p.m;
    bus.EX        = p.ex;
    bus.DataA     = p.a;
    bus.DataB     = p.b;
    bus.imm_value = p.imm;
    bus.RegRs     = p.rs;
    bus.RegRt     = p.rt;
    bus.RegRd     = p.rd;
    bus.OpCode    = p.op;
  endtask

  // One cycle of stimulus: fold the previous edge into the model, then drive the next inputs.
  task automatic step(input bit iv, input instr_t p, input bit ordy, input bit fl);
    @(posedge clock);
    #1;
    if (prev_fl) exp_q.delete();
    else if (prev_acc) exp_q.push_back(prev_p);
    prev_acc = iv && (exp_q.size() < 2);
    prev_fl  = fl;
    prev_p   = p;
    drive(iv, p);
    bus.out_ready = ordy;
    flush = fl;
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      chk("out_valid", 128'(bus.out_valid), 128'(exp_q.size() > 0));
      chk("in_ready", 128'(bus.in_ready), 128'(exp_q.size() < 2));
      if (exp_q.size() > 0) begin
        chk("payload", 128'(observe()), 128'(exp_q[0]));
        if (bus.out_ready) void'(exp_q.pop_front());
      end else begin
        chk("ctrl_zero", 128'({bus.WBreg, bus.Mreg, bus.EXreg}), 128'(0));
      end
    end
  end

  instr_t idle, pa, pb, pc, pd, p;

  initial begin
    clock = 0;
    reset = 1;
    flush = 0;
    idle  = '0;
    drive(0, idle);
    bus.out_ready = 0;
    prev_acc = 0;
    prev_fl  = 0;
    prev_p   = '0;

    #2;
    chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
    chk("rst_in_ready", 128'(bus.in_ready), 128'(1));
    chk("rst_payload", 128'(observe()), 128'(0));
    #10 reset = 0;

    repeat (4) step(0, idle, 0, 0);
`ifdef IDEX_PERF_CNT_EN
    chk("bubble_cnt", 128'(bubble_cnt), 128'(4));
`endif

    for (int i = 0; i < 8; i++) begin
      p = rand_instr();
      p.a = 32'h10 + 32'(i);
      step(1, p, 1, 0);
    end
    repeat (2) step(0, idle, 1, 0);

    pa = rand_instr(); pa.op = 6'h23;
    pb = rand_instr(); pb.op = 6'h2B;
    step(1, pa, 0, 0);
    step(1, pb, 0, 0);
    repeat (2) step(0, idle, 0, 0);
    repeat (3) step(0, idle, 1, 0);

    step(1, pa, 0, 0);
    step(1, pb, 0, 0);
    step(0, idle, 0, 1);
    repeat (2) step(0, idle, 1, 0);

    pc = rand_instr(); pc.op = 6'h08;
    step(1, pc, 1, 1);
    repeat (2) step(0, idle, 1, 0);

    step(1, pa, 0, 0);
    step(1, pb, 0, 0);
    step(0, idle, 0, 0);
    #3 reset = 1;
    #1;
    chk("async_rst_out_valid", 128'(bus.out_valid), 128'(0));
    chk("async_rst_in_ready", 128'(bus.in_ready), 128'(1));
    chk("async_rst_payload", 128'(observe()), 128'(0));
    exp_q.delete();
    prev_acc = 0;
    prev_fl  = 0;
    #7 reset = 0;
    pd = rand_instr();
    step(1, pd, 1, 0);
    repeat (2) step(0, idle, 1, 0);

    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 4) < 3,
           $urandom_range(0, 15) == 0);
    end
    repeat (4) step(0, idle, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/idex_skid_stage.md
Name: idex_skid_stage

Overview:
- Parametrised ID/EX pipeline register with a valid/ready handshake and a 2-entry skid buffer.
- Adds stall back-pressure, synchronous flush and bubble (NOP) insertion on top of plain per-clock capture.
- Sits between decode and execute.
- Control fields are forced to zero whenever no valid instruction is presented, so an invalid slot is a safe NOP for downstream.

Parameters:
- DATA_W, 32, width of DataA/DataB/imm_value.
- REG_W, 5, register-index width (Rs/Rt/Rd).
- OP_W, 6, opcode width.
- WB_W, 2, write-back control width.
- M_W, 3, memory control width.
- EX_W, 4, execute control width.
- CNT_W, 16, perf counter width (optional feature only).

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- flush  in  1  synchronous squash of all held instructions
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  stage can accept; equals !skid_valid
- WB, M, EX  in  WB_W/M_W/EX_W  control fields
- DataA, DataB, imm_value  in  DATA_W each  operands
- RegRs, RegRt, RegRd  in  REG_W each  register indices
- OpCode  in  OP_W  opcode
- out_valid  out  1  execute-side instruction valid
- out_ready  in  1  execute accepts
- WBreg, Mreg, EXreg  out  WB_W/M_W/EX_W  registered control; zero when !out_valid
- DataAreg, DataBreg, imm_valuereg  out  DATA_W  registered operands
- RegRsreg, RegRtreg, RegRdreg  out  REG_W  registered indices
- RegOpCode  out  OP_W  registered opcode

Behaviour:
- Reset (async, active-high): all payload registers 0, main_valid=0, skid_valid=0, out_valid=0, in_ready=1.
- Payload = {WB,M,EX,DataA,DataB,imm_value,RegRs,RegRt,RegRd,OpCode}; PAY_W is the sum of the field widths.
- Accept = in_valid & in_ready. Consume = out_valid & out_ready.
- Latency: 1 cycle from accept to out_valid. Sustained throughput: 1 instruction/cycle while out_ready=1.
- Per clock, no flush:
  - main empty, or consumed this cycle, and skid empty: an accepted input loads main; otherwise main_valid clears on consume.
  - main consumed and skid full: skid moves to main, skid_valid clears. in_ready was 0, so no accept occurs this cycle.
  - main full, not consumed, and accept: input loads skid, skid_valid=1, in_ready falls next cycle.
  - No accept, no consume: hold.
- in_ready is registered-derived (!skid_valid) and has no combinational path from out_ready.
- Flush (priority over everything except reset):
  - main_valid and skid_valid clear next cycle.
  - Any input accepted in the flush cycle is discarded.
  - Data fields hold; control outputs read 0 because out_valid=0.
- Output gating: WBreg/Mreg/EXreg = stored value & {out_valid}. All other outputs show the stored value regardless of out_valid.
- Ordering: strictly FIFO; skid content always leaves before any newer input.
- Reset mid-stall: both entries are lost and in_ready=1 immediately.

Optional Feature:
- Macro: IDEX_PERF_CNT_EN.
- When defined, adds three outputs, each CNT_W wide, saturating at all-ones and cleared by reset:
  - stall_cnt: counts cycles with out_valid & !out_ready.
  - bubble_cnt: counts cycles with !out_valid.
  - flush_cnt: counts cycles with flush asserted.
- When undefined, the ports and counter logic are absent and the datapath is unchanged.

Decomposition:
- Package idex_pkg holds:
  - default width constants (DATA_W, REG_W, OP_W, WB_W, M_W, EX_W);
  - a function computing PAY_W;
  - field offset constants used for payload packing and unpacking.
- One natural sub-module: skid_buf (generic PAY_W-wide, 2-entry valid/ready skid with flush).
- The top level packs and unpacks fields, gates the control outputs and holds the optional counters.

Test Plan:
- Reset then idle:
  - all outputs 0, in_ready=1, out_valid=0.
  - with IDEX_PERF_CNT_EN defined, bubble_cnt increments every cycle.
- Streaming with out_ready=1: 8 back-to-back instructions, DataA=0x10..0x17 → out_valid one cycle later each, DataAreg matches in order, in_ready stays 1.
- Stall:
  - A (OpCode=0x23) then B (0x2B) sent while out_ready=0 → A held at the output, B in skid, in_ready=0.
  - Release out_ready → A then B appear, in order, on consecutive cycles.
- Flush with skid full: flush=1 → next cycle out_valid=0, WBreg/Mreg/EXreg=0, in_ready=1; neither A nor B is ever observed again.
- Flush coinciding with in_valid=1 (OpCode=0x08) → instruction dropped, out_valid=0 the following cycle.
- Async reset asserted mid-stall between clock edges → outputs go to 0 immediately, without waiting for a clock edge; after release, a fresh instruction passes with 1-cycle latency.
